// File: rtl/npc_pkg.sv
// Shared NPC core types: architectural widths and the fetch-queue entry layout.
package npc_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              misalign;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO of {pc, inst, misalign} with single-cycle flush on redirect.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = npc_pkg::PC_W,
    parameter int INST_W = npc_pkg::INST_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        in_pc,
    input  logic [INST_W-1:0]      in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    output logic                   out_misalign,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Widths follow the module parameters so the queue can be resized independently of npc_pkg.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              misalign;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready     = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign out_pc       = mem_q[rd_ptr_q].pc;
    assign out_inst     = mem_q[rd_ptr_q].inst;
    assign out_misalign = mem_q[rd_ptr_q].misalign;
    assign count        = count_q;

    // in_ready comes from registered count only, so a pop never frees a slot in the same cycle.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: in_pc, inst: in_inst, misalign: |in_pc[1:0]};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling buffer between the instruction-fetch stage and decode in the NPC core. Each entry holds a fetched `{pc, inst}` pair. The fetch side pushes with a valid/ready handshake; decode pops with its own valid/ready handshake. A redirect (branch, jump or trap) from execute flushes every entry in one cycle, so no wrong-path instruction reaches decode after the flush edge.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of two and at least 2.
- `PC_W`, 64: PC width.
- `INST_W`, 32: instruction width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a valid pair.
- `in_ready`  out  1  queue can accept a push this cycle.
- `in_pc`  in  PC_W  PC of the fetched instruction.
- `in_inst`  in  INST_W  instruction word, already lane-selected by fetch.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head this cycle.
- `out_pc`  out  PC_W  head PC.
- `out_inst`  out  INST_W  head instruction.
- `out_misalign`  out  1  head PC has `pc[1:0] != 0`; decode raises an instruction-address-misaligned exception.
- `flush`  in  1  redirect; discard all contents.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH-entry circular array. Each entry is `{pc, inst, misalign}`, with `misalign = |in_pc[1:0]` captured at push time.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH. `count` is held in a separate register, 0..DEPTH.
- Push: occurs when `in_valid & in_ready & !flush`. The pair is written at `wr_ptr`, then `wr_ptr` increments.
- Pop: occurs when `out_valid & out_ready & !flush`. `rd_ptr` increments.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `in_ready = (count != DEPTH)`. It depends only on registered state, with no combinational path from `out_ready`. When full, a same-cycle pop does not enable a push.
- `out_valid = (count != 0)`. `out_pc`, `out_inst` and `out_misalign` come combinationally from `entry[rd_ptr]`.
- When empty (`out_valid = 0`), the payload outputs show the stale slot contents. Decode must ignore them.
- Flush has priority over everything. On the edge where `flush = 1`:
  - `wr_ptr`, `rd_ptr` and `count` all go to 0.
  - Any push or pop in that cycle is dropped.
  - Entry contents are not cleared.
- In the cycle after a flush, `in_ready = 1` and `out_valid = 0`.
- No bypass: a pushed pair is never visible at the output in the same cycle it is pushed.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) forces:
  - `wr_ptr = 0`, `rd_ptr = 0`, `count = 0`.
  - All entry fields = 0.
  - Therefore `out_valid = 0`, `in_ready = 1`, `out_pc = 0`, `out_inst = 0`, `out_misalign = 0`, `count = 0`.
- Latency: a push on edge N makes `out_valid = 1` in cycle N+1 (minimum 1 cycle, empty to output).
- Throughput: one push and one pop per cycle in steady state.
- Full boundary: after DEPTH pushes with no pop, `in_ready = 0` from the next cycle. Fetch must hold `in_pc` and `in_inst` stable while `in_valid & !in_ready`.
- Empty boundary: a pop with `count == 1` and no push gives `out_valid = 0` next cycle.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Reset mid-operation: asserting `reset` while full or non-empty clears the queue immediately, with no clock edge required.
- Handshake rules:
  - `out_valid` never drops without a pop or a flush.
  - `out_pc` and `out_inst` stay stable while `out_valid & !out_ready`.

## Structure
- Shared package `npc_pkg` holds:
  - `PC_W = 64` and `INST_W = 32` constants.
  - `fq_entry_t` packed struct `{pc, inst, misalign}`.
- Storage, pointer logic and count logic stay inline in `fetch_queue`. No sub-module is needed.
- The array is a flop array. The DEPTH range is too small to justify a RAM macro.

## Test plan
- Fill/drain: after reset, push PCs 0x80000000, 0x80000004, 0x80000008, 0x8000000c with `out_ready = 0`. Expect `count = 4` and `in_ready = 0`. Then hold `out_ready = 1` for 4 cycles: the same PCs and instructions come out in order, then `out_valid = 0`.
- Streaming: with `in_valid = out_ready = 1` for 20 cycles and PC incrementing by 4, `count` stays at 1 after the first cycle. Output PC sequence equals input PC sequence delayed by 1 cycle, with pointers wrapping at DEPTH.
- Full with pop: with the queue full, assert `in_valid` and `out_ready` together. The push is refused (`in_ready = 0`), the pop occurs, and `count = 3`. The held pair is accepted the next cycle.
- Flush: with 3 entries, assert `flush` together with `in_valid` and `out_ready`. Next cycle: `count = 0`, `out_valid = 0`, `in_ready = 1`. A push of 0x80001000 afterwards appears at `out_pc` one cycle later.
- Misalign: push `in_pc = 0x80000002`. Expect `out_misalign = 1` with that entry. A following 0x80000004 entry gives `out_misalign = 0`.
- Async reset: with 2 entries and no clock edge, pull `reset` low. Immediately `out_valid = 0`, `count = 0`, `out_pc = 0`. After release, the queue accepts a push normally.
